vga_capture: RTL and testbench
==============================

# vga_capture

Frame-grab block that sits on the video output stream (hs, vs, de and 4-bit RGB) and captures one full Spectrum screen back into memory. It recovers the 256x192 paper area from the 2x-scaled 640x480 stream and packs each Spectrum pixel into a 4-bit colour code, two pixels per byte. It writes the bytes to a capture buffer through a valid/ready port behind a small FIFO. Its uses are screenshot dumps and self-checking of the video path.

## Interface
- HB, 64: first active-area column of the paper area, counted in clocks from the rising edge of de.
- VB, 48: first active-area line of the paper area, counted in de lines from the start of the frame.
- FIFO_DEPTH, 4: write FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  pixel clock, same clock as the video generator.
- reset  in  1  asynchronous, active-high.
- vga_r, vga_g, vga_b  in  4 each  video colour.
- vga_hs, vga_vs  in  1 each  syncs, active-low.
- vga_de  in  1  active-video enable.
- arm  in  1  single-cycle pulse that requests capture of the next complete frame.
- busy  out  1  high in WAIT, CAPTURE and DRAIN.
- done  out  1  sticky completion flag, cleared by arm.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full. Cleared by arm.
- cap_addr  out  15  byte address, 0 to 24575.
- cap_data  out  8  packed pixel pair.
- cap_valid  out  1  FIFO head is valid.
- cap_ready  in  1  sink accepts the head on this clock.
- crc  out  16  running CRC; present only with the macro defined.

## Operation
- **Position tracking**
  - hpos: 10 bits. Cleared on the clock after de rises; increments while de is high.
  - line: 9 bits. Cleared on the falling edge of vs. Increments on each falling edge of de.
- **Sampling window**
  - Sample where line−VB is in 0..383 and even.
  - Sample where hpos−HB is in 0..511 and even.
  - This gives one sample per Spectrum pixel: x = (hpos−HB)/2, y = (line−VB)/2.
- **Colour code**: nibble = {vga_r[3], vga_r[2], vga_g[2], vga_b[2]}.
  - Bit 3 is bright.
  - Other bits of the inputs are ignored.
- **Packing**
  - Even x goes in bits [7:4]; odd x goes in bits [3:0].
  - On odd x, push {data, addr = y*128 + x/2} into the FIFO.
- **State machine**
  - IDLE: arm → WAIT. arm also clears done and overflow.
  - WAIT: vs falling edge → CAPTURE.
  - CAPTURE: sample and push. The push of y=191, x=255 → DRAIN.
  - DRAIN: FIFO empty → IDLE, and done is set to 1.
- **Boundary cases**
  - arm while busy is ignored.
  - A vs falling edge during CAPTURE before completion is a short frame: go to DRAIN. done is still set, and overflow is unchanged.
  - A push into a full FIFO drops the byte and sets overflow. A pop on the same clock frees space, so a simultaneous pop and push never overflows.
- **Output port**: the FIFO head is held stable while cap_valid=1 and cap_ready=0.

## Timing
- Reset values: busy=0, done=0, overflow=0, cap_valid=0, cap_addr=0, cap_data=0, crc=16'hFFFF. State is IDLE and all counters are 0.
- Inputs are registered once. Sampling decisions use the registered values.
- Latency from the odd-x sample to cap_valid:
  - 2 clocks when the FIFO is empty: one input register plus one FIFO write.
  - When the FIFO is not empty, the byte appears behind the earlier entries.
- Maximum push rate is 1 byte per 4 clocks. A sink with cap_ready held high never overflows.
- A frame takes 24576 pushes. done rises on the clock after the last pop.
- Asserting reset mid-capture clears everything immediately. A partial frame is not resumed.

## Configuration
- VGA_CAPTURE_CRC_EN
  - Defined: port crc is present. It is a CRC-16/CCITT (polynomial 0x1021, initial value 0xFFFF, MSB first) over cap_data, updated on every accepted pop. It is reinitialised to 0xFFFF by arm.
  - Undefined: the crc port and its logic are absent. All other behaviour is identical.

## Test plan
- Border-only frame, then an all-black paper area, arm, cap_ready=1 → 24576 writes, all cap_data=0x00, addresses 0..24575 in order, done=1, overflow=0.
- Paper with pixel (0,0) bright white (r=g=b=4'hF) and (1,0) blue (b=4'h7) → first write addr 0, data 0xF1.
- Pixel (255,191) red, non-bright (r=4'h7) → last write addr 24575, data[3:0]=0x4.
- cap_ready held low for 40 clocks mid-line → overflow=1 after the 5th pending byte. cap_data is stable throughout the stall, and done is still set at frame end.
- arm pulsed during CAPTURE → no effect. Reset asserted at line 100 → busy=0 and cap_valid=0 on the next clock edge.
- With VGA_CAPTURE_CRC_EN defined, all-0x00 frame → crc equals the model value for 24576 zero bytes. A following arm resets crc to 0xFFFF.

Source files
------------

// File: rtl/vga_capture.sv
// Frame grabber: recovers the 256x192 paper area from the 2x-scaled 640x480 video stream and
// streams packed 4-bit pixel pairs out through a small FIFO. Define VGA_CAPTURE_CRC_EN for the crc port.
module vga_capture #(
   parameter int HB         = 64,
   parameter int VB         = 48,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  vga_r,
   input  logic [3:0]  vga_g,
   input  logic [3:0]  vga_b,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic        vga_de,
   input  logic        arm,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [14:0] cap_addr,
   output logic [7:0]  cap_data,
   output logic        cap_valid,
   input  logic        cap_ready
`ifdef VGA_CAPTURE_CRC_EN
   ,
   output logic [15:0] crc
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

   state_t        state_q;
   logic          busy_q, done_q, ovf_q;
   logic [3:0]    nib_q, hi_q;
   logic          de_q, de_prev_q, vs_q, vs_prev_q, arm_q;
   logic [9:0]    hpos_q, hpos_d;
   logic [8:0]    line_q, line_d;
   logic [7:0]    dmem_q [FIFO_DEPTH];
   logic [14:0]   amem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;

   logic          de_fall, vs_fall;
   logic [10:0]   hoff;
   logic [9:0]    voff;
   logic          h_in, v_in, sample, push, push_ok, pop, drop, last_px;
   logic [7:0]    x, y;

   logic unused_in;
   assign unused_in = ^{vga_hs, vga_r[1:0], vga_g[3], vga_g[1:0], vga_b[3], vga_b[1:0]};

   // Input register stage: only the colour bits that form the code are kept
   always_ff @(posedge clk) begin
      nib_q <= {vga_r[3], vga_r[2], vga_g[2], vga_b[2]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         de_q      <= 1'b0;
         de_prev_q <= 1'b0;
         vs_q      <= 1'b1;
         vs_prev_q <= 1'b1;
         arm_q     <= 1'b0;
         hpos_q    <= '0;
         line_q    <= '0;
      end else begin
         de_q      <= vga_de;
         de_prev_q <= de_q;
         vs_q      <= vga_vs;
         vs_prev_q <= vs_q;
         arm_q     <= arm;
         hpos_q    <= hpos_d;
         line_q    <= line_d;
      end
   end

   assign de_fall = de_prev_q & ~de_q;
   assign vs_fall = vs_prev_q & ~vs_q;

   // hpos_q is the column of the pixel currently held in the input register
   always_comb begin
      hpos_d = de_q ? hpos_q + 10'd1 : '0;
      line_d = line_q;
      if (vs_fall)
         line_d = '0;
      else if (de_fall)
         line_d = line_q + 9'd1;
   end

   assign hoff    = {1'b0, hpos_q} - 11'(HB);
   assign voff    = {1'b0, line_q} - 10'(VB);
   assign h_in    = (hpos_q >= 10'(HB)) && (hoff < 11'd512) && !hoff[0];
   assign v_in    = (line_q >= 9'(VB)) && (voff < 10'd384) && !voff[0];
   assign x       = hoff[8:1];
   assign y       = voff[8:1];
   assign sample  = (state_q == S_CAPTURE) && de_q && h_in && v_in;
   assign push    = sample && x[0];
   assign last_px = push && (y == 8'd191) && (x == 8'hFF);

   assign cap_valid = (cnt_q != '0);
   assign pop       = cap_valid && cap_ready;
   assign push_ok   = push && ((cnt_q != FULL_CNT) || pop);
   assign drop      = push && (cnt_q == FULL_CNT) && !pop;
   assign cap_data  = cap_valid ? dmem_q[rd_q] : '0;
   assign cap_addr  = cap_valid ? amem_q[rd_q] : '0;

   always_comb begin
      cnt_d = cnt_q;
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Packing / FIFO write stage
   always_ff @(posedge clk) begin
      if (sample && !x[0])
         hi_q <= nib_q;
      if (push_ok) begin
         dmem_q[wr_q] <= {hi_q, nib_q};
         amem_q[wr_q] <= {y, x[7:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm_q) begin
                  state_q <= S_WAIT;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (vs_fall)
                  state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (drop)
                  ovf_q <= 1'b1;
               // a new vsync before the last pixel ends a short frame
               if (last_px || vs_fall)
                  state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;

`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc_q;

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ d[i])
            r = {r[14:0], 1'b0} ^ 16'h1021;
         else
            r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         crc_q <= 16'hFFFF;
      else if (state_q == S_IDLE && arm_q)
         crc_q <= 16'hFFFF;
      else if (pop)
         crc_q <= crc16_step(crc_q, cap_data);
   end

   assign crc = crc_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: drives compressed video frames (cheap one-clock lines,
// full 640-clock lines only where paper pixels matter) and checks every popped byte.
module tb_vga_capture;

   localparam int HB = 64;
   localparam int VB = 48;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_de;
   logic        arm;
   logic        busy, done, overflow;
   logic [14:0] cap_addr;
   logic [7:0]  cap_data;
   logic        cap_valid;
   logic        cap_ready;
`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc;
`endif

   vga_capture #(.HB(HB), .VB(VB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .arm(arm), .busy(busy), .done(done), .overflow(overflow),
      .cap_addr(cap_addr), .cap_data(cap_data),
      .cap_valid(cap_valid), .cap_ready(cap_ready)
`ifdef VGA_CAPTURE_CRC_EN
      , .crc(crc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          drop_ok  = 0;
   int          drops    = 0;
   logic [15:0] crc_model = 16'hFFFF;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [3:0] nib(input logic [11:0] rgb);
      return {rgb[11], rgb[10], rgb[6], rgb[2]};
   endfunction

   function automatic logic [11:0] paper_rgb(input int kind, input int px, input int py);
      if (kind == 1)                return 12'h000;
      if (px == 0   && py == 0)     return 12'hFFF;
      if (px == 1   && py == 0)     return 12'h007;
      if (px == 255 && py == 191)   return 12'h700;
      return 12'($urandom);
   endfunction

   function automatic bit is_full(input int kind, input int ln);
      case (kind)
         0:       return (ln == 48) || (ln == 50) || (ln == 430);
         1:       return (ln == 48) || (ln == 49) || (ln == 240) || (ln == 430);
         2:       return (ln == 48) || (ln == 430);
         3:       return (ln == 48);
         default: return (ln == 100);
      endcase
   endfunction

   task automatic tick(input logic de, input logic vs, input logic [11:0] rgb);
      @(negedge clk);
      vga_de = de;
      vga_vs = vs;
      vga_hs = de | ~vs;
      {vga_r, vga_g, vga_b} = rgb;
   endtask

   task automatic pulse_arm();
      @(negedge clk);
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   // Pops are taken on the upcoming posedge when valid and ready are both high here
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset && cap_valid && cap_ready) begin
            if (drop_ok)
               while (sb_q.size() > 0 && sb_q[0].addr != cap_addr) begin
                  void'(sb_q.pop_front());
                  drops++;
               end
            if (sb_q.size() == 0)
               check("sb_unexpected_pop", 32'(cap_addr), 32'h7FFF_FFFF);
            else begin
               exp_t e;
               e = sb_q.pop_front();
               if (!drop_ok) check("cap_addr", 32'(cap_addr), 32'(e.addr));
               check("cap_data", 32'(cap_data), 32'(e.data));
               crc_model = crc_ref(crc_model, e.data);
            end
         end else if (!reset && cap_valid && !cap_ready && sb_q.size() > 0) begin
            check("stall_addr", 32'(cap_addr), 32'(sb_q[0].addr));
            check("stall_data", 32'(cap_data), 32'(sb_q[0].data));
         end
      end
   end

   task automatic reset_mid_capture();
      check("pre_reset_busy", 32'(busy), 32'd1);
      check("pre_reset_ovf", 32'(overflow), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(cap_valid), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(cap_data), 32'd0);
      sb_q.delete();
      cap_ready = 1'b1;
      tick(1'b0, 1'b1, 12'h000);
      reset = 1'b0;
      repeat (3) tick(1'b0, 1'b1, 12'h000);
   endtask

   task automatic drive_line(input int kind, input int ln, output bit aborted);
      int          voff;
      bit          vsamp;
      logic [3:0]  hi;
      logic [11:0] rgb;
      exp_t        e;
      aborted = 0;
      hi      = '0;
      if (!is_full(kind, ln)) begin
         tick(1'b1, 1'b1, 12'($urandom));
         tick(1'b0, 1'b1, 12'($urandom));
         tick(1'b0, 1'b1, 12'($urandom));
         return;
      end
      voff  = ln - VB;
      vsamp = (voff >= 0) && (voff < 384) && (voff % 2 == 0);
      for (int c = 0; c < 640; c++) begin
         int h;
         h = c - HB;
         if (vsamp && h >= 0 && h < 512 && h % 2 == 0) begin
            rgb = paper_rgb(kind, h / 2, voff / 2);
            if ((h / 2) % 2 == 0)
               hi = nib(rgb);
            else begin
               e.addr = 15'((voff / 2) * 128 + h / 4);
               e.data = {hi, nib(rgb)};
               sb_q.push_back(e);
            end
         end else
            rgb = 12'($urandom);
         tick(1'b1, 1'b1, rgb);
         if (kind == 2 && ln == 48) begin
            if (c == 200) cap_ready = 1'b0;
            if (c == 240) cap_ready = 1'b1;
         end
         if (kind == 4 && ln == 100) begin
            if (c == 100) cap_ready = 1'b0;
            if (c == 300) begin
               reset_mid_capture();
               aborted = 1;
               return;
            end
         end
      end
      tick(1'b0, 1'b1, 12'($urandom));
      tick(1'b0, 1'b1, 12'($urandom));
   endtask

   task automatic run_frame(input int kind);
      bit ab;
      int last_line;
      tick(1'b0, 1'b0, 12'h000);
      tick(1'b0, 1'b0, 12'h000);
      tick(1'b0, 1'b1, 12'h000);
      last_line = (kind == 3) ? 99 : ((kind == 4) ? 100 : 430);
      for (int ln = 0; ln <= last_line; ln++) begin
         drive_line(kind, ln, ab);
         if (ab) return;
         if (kind == 0 && ln == 60) begin
            pulse_arm();
            repeat (3) tick(1'b0, 1'b1, 12'h000);
            #1;
            check("arm_in_capture_busy", 32'(busy), 32'd1);
         end
      end
      if (kind == 3) begin
         tick(1'b0, 1'b0, 12'h000);
         tick(1'b0, 1'b0, 12'h000);
         tick(1'b0, 1'b1, 12'h000);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         tick(1'b0, 1'b1, 12'h000);
         #1;
         n++;
      end
      check("done_set", 32'(done), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached before the end of the test");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      int kinds[6] = '{0, 1, 2, 3, 4, 1};
      reset     = 1'b1;
      arm       = 1'b0;
      cap_ready = 1'b1;
      vga_de    = 1'b0;
      vga_vs    = 1'b1;
      vga_hs    = 1'b1;
      {vga_r, vga_g, vga_b} = 12'h000;
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);
      check("reset_valid", 32'(cap_valid), 32'd0);
      check("reset_addr", 32'(cap_addr), 32'd0);
      check("reset_data", 32'(cap_data), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
      check("reset_crc", 32'(crc), 32'hFFFF);
`endif
      @(negedge clk);
      reset = 1'b0;

      foreach (kinds[k]) begin
         pulse_arm();
         repeat (3) tick(1'b0, 1'b1, 12'h000);
         #1;
         check("armed_busy", 32'(busy), 32'd1);
         check("armed_done", 32'(done), 32'd0);
         check("armed_ovf", 32'(overflow), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
         check("armed_crc", 32'(crc), 32'hFFFF);
`endif
         drops     = 0;
         drop_ok   = (kinds[k] == 2);
         crc_model = 16'hFFFF;
         run_frame(kinds[k]);
         if (kinds[k] != 4) begin
            wait_done();
            repeat (2) tick(1'b0, 1'b1, 12'h000);
            #1;
            check("end_busy", 32'(busy), 32'd0);
            check("end_ovf", 32'(overflow), (kinds[k] == 2) ? 32'd1 : 32'd0);
            check("sb_left", 32'(sb_q.size()), 32'd0);
            if (kinds[k] == 2)
               check("drops_seen", 32'(drops > 0), 32'd1);
`ifdef VGA_CAPTURE_CRC_EN
            check("frame_crc", 32'(crc), 32'(crc_model));
`endif
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
